// File: rtl/character_motion_if.sv
`default_nettype none
// ============================================================================
// Module      : character_motion_if
// Description : Bundles the keycode, free-path and motion-output signals
//               exchanged between the character motion controller and the
//               surrounding keyboard/collision logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface character_motion_if;
    logic [7:0]        keycode0;
    logic [7:0]        keycode1;
    logic              free_left;
    logic              free_right;
    logic              free_up;
    logic              free_down;
    logic              jump_inhibit;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [9:0]        box_l;
    logic [9:0]        box_r;
    logic [9:0]        box_t;
    logic [9:0]        box_b;
    logic signed [5:0] vel_y;
    logic              airborne;
    logic              moving_left;
    logic              moving_right;
    logic              facing_left;
    logic [1:0]        anim_frame;

    // Keyboard decoder / collision logic side
    modport master (
        output keycode0, keycode1, free_left, free_right, free_up, free_down,
               jump_inhibit,
        input  pos_x, pos_y, box_l, box_r, box_t, box_b, vel_y, airborne,
               moving_left, moving_right, facing_left, anim_frame
    );

    // Motion controller side
    modport slave (
        input  keycode0, keycode1, free_left, free_right, free_up, free_down,
               jump_inhibit,
        output pos_x, pos_y, box_l, box_r, box_t, box_b, vel_y, airborne,
               moving_left, moving_right, facing_left, anim_frame
    );
endinterface
`default_nettype wire

// File: rtl/character_motion.sv
`default_nettype none
// ============================================================================
// Module      : character_motion
// Description : Per-frame movement controller for the playable character.
//               Decodes two keycodes, integrates gravity into a signed
//               vertical velocity, runs a grounded/rising/falling state
//               machine and produces registered position, bounding box,
//               facing and walk-animation frame.
//               Optional feature macro: CHARACTER_MOTION_JUMP_BUFFER_EN
//               (remembers an up press made shortly before landing).
// Revision    : 1.0 - initial release
// ============================================================================
module character_motion #(
    parameter int         X_START    = 32,
    parameter int         Y_START    = 388,
    parameter int         X_MIN      = 0,
    parameter int         X_MAX      = 639,
    parameter int         Y_MIN      = 0,
    parameter int         Y_MAX      = 479,
    parameter int         HALF_SIZE  = 13,
    parameter int         WALK_STEP  = 3,
    parameter int         JUMP_VEL   = 8,
    parameter int         GRAVITY    = 1,
    parameter int         VMAX_FALL  = 6,
    parameter int         ANIM_DIV   = 5,
    parameter logic [7:0] KEY_UP     = 8'h1A,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07,
    parameter int         BUF_FRAMES = 4
) (
    input  logic               frame_clk,
    input  logic               Reset,
    character_motion_if.slave  bus
);

    // Centre-position limits so the box stays on screen; 11-bit signed
    // arithmetic keeps the sums free of wrap-around before clamping.
    localparam logic signed [10:0] c_X_LO   = 11'(X_MIN + HALF_SIZE);
    localparam logic signed [10:0] c_X_HI   = 11'(X_MAX - HALF_SIZE);
    localparam logic signed [10:0] c_Y_LO   = 11'(Y_MIN + HALF_SIZE);
    localparam logic signed [10:0] c_Y_HI   = 11'(Y_MAX - HALF_SIZE);
    localparam logic signed [10:0] c_WALK   = 11'(WALK_STEP);
    localparam logic        [9:0]  c_HALF   = 10'(HALF_SIZE);
    localparam logic        [9:0]  c_X0     = 10'(X_START);
    localparam logic        [9:0]  c_Y0     = 10'(Y_START);
    localparam logic signed [5:0]  c_VY_JMP = 6'(-JUMP_VEL);
    localparam logic signed [6:0]  c_GRAV   = 7'(GRAVITY);
    localparam logic signed [6:0]  c_VMAX   = 7'(VMAX_FALL);
    localparam int                 c_DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        S_GROUNDED = 2'd0,
        S_RISING   = 2'd1,
        S_FALLING  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [9:0]          r_pos_x;
    logic [9:0]          r_pos_y;
    logic [9:0]          r_box_l;
    logic [9:0]          r_box_r;
    logic [9:0]          r_box_t;
    logic [9:0]          r_box_b;
    logic signed [5:0]   r_vel_y;
    logic                r_airborne;
    logic                r_moving_left;
    logic                r_moving_right;
    logic                r_facing_left;
    logic [1:0]          r_anim;
    logic [c_DIV_W-1:0]  r_div;

    logic                w_up;
    logic                w_left;
    logic                w_right;
    logic                w_jump_req;
    logic                w_launch;
    logic                w_land;
    logic signed [10:0]  w_x_sum;
    logic [9:0]          w_x_next;
    logic                w_mov_l;
    logic                w_mov_r;
    logic signed [10:0]  w_vy_ext;
    logic signed [10:0]  w_y_sum;
    logic signed [10:0]  w_y_clamp;
    logic signed [6:0]   w_vy_inc;
    logic                w_floor;
    logic [9:0]          w_y_next;
    logic signed [5:0]   w_vy_next;
    logic                w_air_next;
    logic                w_div_wrap;
    logic                w_unused_msb;

    assign w_up    = (bus.keycode0 == KEY_UP)    || (bus.keycode1 == KEY_UP);
    assign w_left  = (bus.keycode0 == KEY_LEFT)  || (bus.keycode1 == KEY_LEFT);
    assign w_right = (bus.keycode0 == KEY_RIGHT) || (bus.keycode1 == KEY_RIGHT);

    // Horizontal step with saturation; opposing keys cancel out.
    always_comb begin
        w_x_sum = $signed({1'b0, r_pos_x});
        if (w_left && !w_right && bus.free_left) begin
            w_x_sum = $signed({1'b0, r_pos_x}) - c_WALK;
            if (w_x_sum < c_X_LO) w_x_sum = c_X_LO;
        end else if (w_right && !w_left && bus.free_right) begin
            w_x_sum = $signed({1'b0, r_pos_x}) + c_WALK;
            if (w_x_sum > c_X_HI) w_x_sum = c_X_HI;
        end
    end

    assign w_x_next = w_x_sum[9:0];
    assign w_mov_l  = (w_x_next < r_pos_x);
    assign w_mov_r  = (w_x_next > r_pos_x);

    // Candidate vertical move and next velocity, shared by both airborne states.
    assign w_vy_ext = {{5{r_vel_y[5]}}, r_vel_y};
    assign w_y_sum  = $signed({1'b0, r_pos_y}) + w_vy_ext;
    assign w_vy_inc = $signed({r_vel_y[5], r_vel_y}) + c_GRAV;
    assign w_floor  = (w_y_sum >= c_Y_HI);

    // Saturate the vertical sum to the screen.
    always_comb begin
        w_y_clamp = w_y_sum;
        if (w_y_sum < c_Y_LO)      w_y_clamp = c_Y_LO;
        else if (w_y_sum > c_Y_HI) w_y_clamp = c_Y_HI;
    end

    assign w_unused_msb = w_x_sum[10] ^ w_y_clamp[10];

`ifdef CHARACTER_MOTION_JUMP_BUFFER_EN
    localparam int c_BUF_W = $clog2(BUF_FRAMES + 1);

    logic [c_BUF_W-1:0] r_buf_cnt;
    logic               r_buf_pending;

    assign w_jump_req = w_up || r_buf_pending;

    // Jump buffer: an up press while falling is remembered for a few frames
    // and, if still live on landing, arms a launch on the next grounded frame.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_buf_cnt     <= '0;
            r_buf_pending <= 1'b0;
        end else begin
            r_buf_pending <= w_land && (r_buf_cnt != '0);
            if (w_launch)
                r_buf_cnt <= '0;
            else if ((r_state == S_FALLING) && w_up)
                r_buf_cnt <= c_BUF_W'(BUF_FRAMES);
            else if (r_buf_cnt != '0)
                r_buf_cnt <= r_buf_cnt - 1'b1;
        end
    end
`else
    assign w_jump_req = w_up;
`endif

    // Vertical state register.
    always_ff @(posedge frame_clk) begin
        if (Reset) r_state <= S_FALLING;
        else       r_state <= w_state_next;
    end

    // Vertical next-state, position and velocity.
    always_comb begin
        w_state_next = r_state;
        w_y_next     = r_pos_y;
        w_vy_next    = r_vel_y;
        w_launch     = 1'b0;
        w_land       = 1'b0;
        case (r_state)
            S_GROUNDED: begin
                w_vy_next = '0;
                if (bus.free_down) begin
                    w_state_next = S_FALLING;
                end else if (w_jump_req && bus.free_up && !bus.jump_inhibit) begin
                    w_state_next = S_RISING;
                    w_vy_next    = c_VY_JMP;
                    w_launch     = 1'b1;
                end
            end
            S_RISING: begin
                if (!bus.free_up) begin
                    w_state_next = S_FALLING;
                    w_vy_next    = '0;
                end else begin
                    w_y_next  = w_y_clamp[9:0];
                    w_vy_next = w_vy_inc[5:0];
                    if (!w_vy_inc[6]) w_state_next = S_FALLING;
                end
            end
            S_FALLING: begin
                if (!bus.free_down) begin
                    w_state_next = S_GROUNDED;
                    w_vy_next    = '0;
                    w_land       = 1'b1;
                end else begin
                    w_y_next = w_y_clamp[9:0];
                    if (w_floor) begin
                        // Bottom of the screen acts as solid floor.
                        w_state_next = S_GROUNDED;
                        w_vy_next    = '0;
                        w_land       = 1'b1;
                    end else if (w_vy_inc > c_VMAX) begin
                        w_vy_next = c_VMAX[5:0];
                    end else begin
                        w_vy_next = w_vy_inc[5:0];
                    end
                end
            end
            default: begin
                w_state_next = S_FALLING;
                w_vy_next    = '0;
            end
        endcase
    end

    assign w_air_next = (w_state_next != S_GROUNDED);
    assign w_div_wrap = (r_div == c_DIV_LAST);

    // Registered position, box, velocity and direction outputs.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_pos_x        <= c_X0;
            r_pos_y        <= c_Y0;
            r_box_l        <= c_X0 - c_HALF;
            r_box_r        <= c_X0 + c_HALF;
            r_box_t        <= c_Y0 - c_HALF;
            r_box_b        <= c_Y0 + c_HALF;
            r_vel_y        <= '0;
            r_airborne     <= 1'b1;
            r_moving_left  <= 1'b0;
            r_moving_right <= 1'b0;
            r_facing_left  <= 1'b0;
        end else begin
            r_pos_x        <= w_x_next;
            r_pos_y        <= w_y_next;
            r_box_l        <= w_x_next - c_HALF;
            r_box_r        <= w_x_next + c_HALF;
            r_box_t        <= w_y_next - c_HALF;
            r_box_b        <= w_y_next + c_HALF;
            r_vel_y        <= w_vy_next;
            r_airborne     <= w_air_next;
            r_moving_left  <= w_mov_l;
            r_moving_right <= w_mov_r;
            if (w_mov_l)      r_facing_left <= 1'b1;
            else if (w_mov_r) r_facing_left <= 1'b0;
        end
    end

    // Animation divider and frame selection.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_div  <= '0;
            r_anim <= 2'd0;
        end else if (w_div_wrap) begin
            r_div <= '0;
            if (w_air_next)             r_anim <= 2'd3;
            else if (w_mov_l | w_mov_r) r_anim <= (r_anim == 2'd1) ? 2'd2 : 2'd1;
            else                        r_anim <= 2'd0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign bus.pos_x        = r_pos_x;
    assign bus.pos_y        = r_pos_y;
    assign bus.box_l        = r_box_l;
    assign bus.box_r        = r_box_r;
    assign bus.box_t        = r_box_t;
    assign bus.box_b        = r_box_b;
    assign bus.vel_y        = r_vel_y;
    assign bus.airborne     = r_airborne;
    assign bus.moving_left  = r_moving_left;
    assign bus.moving_right = r_moving_right;
    assign bus.facing_left  = r_facing_left;
    assign bus.anim_frame   = r_anim;

endmodule
`default_nettype wire
